mult_issue_sched: RTL
=====================

MULT_ISSUE_SCHED -- requirements
Module: mult_issue_sched

Interface
REQ-001 Parameters (name, default, meaning): NUM_REQ, 3, issue ways sharing the multiplier; TAG_W, 6, physical destination tag width; LAT, 2, multiplier latency in cycles; DEPTH, 4, result buffer entries (DEPTH >= LAT+1).
REQ-002 Ports (name, direction, width, meaning), in this order:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- pipe_flush  in  1  squash all in-flight and buffered operations.
- req_valid  in  NUM_REQ  per-way multiply request.
- req_func  in  NUM_REQ x ALU_FUNC  per-way op (ALU_MUL/MULH/MULHSU/MULHU).
- req_opa, req_opb  in  NUM_REQ x `XLEN  per-way operands.
- req_tag  in  NUM_REQ x TAG_W  per-way destination tag.
- req_ready  out  NUM_REQ  one-hot grant; handshake on req_valid & req_ready.
- mult_mcand, mult_mplier  out  `XLEN  operands to the multiplier.
- mult_func  out  ALU_FUNC  op to the multiplier.
- mult_result  in  `XLEN  multiplier result, valid LAT cycles after issue.
- cdb_ready  in  1  writeback bus accepts this cycle.
- cdb_valid  out  1  buffered result available.
- cdb_tag  out  TAG_W  tag of head result.
- cdb_result  out  `XLEN  head result.
- busy  out  1  any operation in flight or buffered.

Function
REQ-003 The block SHALL assert at most one req_ready bit per cycle, and only on a way whose req_valid is high.
REQ-004 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and proceeds upward with wrap; after grant to way i, rr_ptr <= (i+1) mod NUM_REQ; rr_ptr is unchanged when nothing is granted.
REQ-005 A grant SHALL be issued only if (buffer count + in-flight count) < DEPTH, evaluated on current registered state; a same-cycle pop SHALL NOT free a credit.
REQ-006 No grant SHALL be issued while pipe_flush or rst is high.
REQ-007 In the grant cycle, mult_mcand/mult_mplier/mult_func SHALL combinationally carry the granted way's operands/func; with no grant they SHALL be 0/0/ALU_ADD.
REQ-008 A LAT-stage shadow pipeline SHALL carry {valid, tag} for each grant, aligned with the multiplier's internal pipeline.
REQ-009 When the last shadow stage is valid, mult_result and its tag SHALL be written into the result FIFO at the end of that cycle (grant in cycle T -> written end of T+LAT -> cdb_valid in T+LAT+1).
REQ-010 cdb_valid SHALL be high whenever the FIFO is non-empty; cdb_tag/cdb_result SHALL show the oldest entry; an entry SHALL pop on cdb_valid & cdb_ready.
REQ-011 Results SHALL leave in grant order; no loss, duplication or reordering across stalls of any length.
REQ-012 Simultaneous FIFO push and pop SHALL be supported in the same cycle, count unchanged; pop with empty FIFO SHALL have no effect.
REQ-013 FIFO pointers SHALL wrap modulo DEPTH; by REQ-005 a push into a full FIFO cannot occur (assertion in bench).
REQ-014 pipe_flush SHALL, on the next edge, clear all shadow-stage valids, empty the FIFO and drop any same-cycle push/pop; rr_ptr SHALL be preserved.
REQ-015 busy SHALL equal (any shadow valid) | (FIFO count != 0).

Reset
REQ-016 On rst high at a clock edge: shadow valids 0, FIFO empty (count 0, pointers 0), rr_ptr 0.
REQ-017 While and after reset: req_ready 0, cdb_valid 0, busy 0, mult_func ALU_ADD, mult_mcand/mult_mplier 0; cdb_tag/cdb_result don't-care while cdb_valid is 0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight results; none SHALL appear on the CDB afterwards.

Verification
REQ-019 Single op: way1 MUL opa=7 opb=6 tag=5 at T, cdb_ready=1 -> req_ready=3'b010 at T, cdb_valid at T+3 with tag 5, result 42, busy low at T+4.
REQ-020 Round-robin: all three ways valid continuously from reset -> grants in order 0,1,2,0,1,2; CDB tags in the same order, one per cycle from T+3.
REQ-021 Backpressure: cdb_ready=0, all ways valid -> exactly 4 grants, then req_ready 0; raising cdb_ready -> 4 results in order, grants resume one cycle after the first pop.
REQ-022 Flush: 2 ops in flight + 1 buffered, pipe_flush one cycle -> cdb_valid 0 next cycle, busy 0, no stale tag later; the next grant goes to the way after the last granted way.
REQ-023 Signed ops: MULH opa=0xFFFFFFFF opb=0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL -> 0x00000001.
REQ-024 Reset mid-operation: rst pulsed with 3 ops outstanding -> all outputs at reset values, no CDB output thereafter until a new grant.

Source files
------------

// File: rtl/mult_issue_sched.sv
// rtl/mult_issue_sched.sv - round-robin issue of multiply requests onto one shared pipelined multiplier with an in-order result buffer
`ifndef XLEN
`define XLEN 32
`endif

typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_MUL    = 4'h8,
    ALU_MULH   = 4'h9,
    ALU_MULHSU = 4'ha,
    ALU_MULHU  = 4'hb
} ALU_FUNC;

module mult_issue_sched #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 6,
    parameter int LAT     = 2,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_flush,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  ALU_FUNC              req_func [NUM_REQ],
    input  logic [`XLEN-1:0]     req_opa  [NUM_REQ],
    input  logic [`XLEN-1:0]     req_opb  [NUM_REQ],
    input  logic [TAG_W-1:0]     req_tag  [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [`XLEN-1:0]     mult_mcand,
    output logic [`XLEN-1:0]     mult_mplier,
    output ALU_FUNC              mult_func,
    input  logic [`XLEN-1:0]     mult_result,
    input  logic                 cdb_ready,
    output logic                 cdb_valid,
    output logic [TAG_W-1:0]     cdb_tag,
    output logic [`XLEN-1:0]     cdb_result,
    output logic                 busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rr_ptr;
    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;

    logic [LAT-1:0]   sh_valid;
    logic [TAG_W-1:0] sh_tag [LAT];

    logic [TAG_W-1:0]  fifo_tag [DEPTH];
    logic [`XLEN-1:0]  fifo_res [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_nonempty;

    logic [CNT_W:0]    inflight;
    logic [CNT_W:0]    occupancy;
    logic              credit_ok;
    logic              push;
    logic              pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_nonempty = (fifo_count != '0);
    assign push          = sh_valid[LAT-1];
    assign pop           = fifo_nonempty & cdb_ready;

    // Credits: every grant owns a buffer slot from issue until it leaves on the CDB
    always_comb begin
        inflight = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight = inflight + {{CNT_W{1'b0}}, sh_valid[k]};
        end
        occupancy = {1'b0, fifo_count} + inflight;
        credit_ok = (occupancy < (CNT_W + 1)'(DEPTH));
    end

    // Round-robin search starting at rr_ptr, wrapping upward; one grant at most
    always_comb begin : arb
        int                cand;
        logic [PTR_W-1:0]  cand_idx;
        cand      = 0;
        cand_idx  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        if (!rst && !pipe_flush && credit_ok) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                cand_idx = PTR_W'(cand);
                if (!grant_any && req_valid[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Steer the granted way's operands to the multiplier; idle drives a harmless add of zeros
    always_comb begin
        mult_mcand  = '0;
        mult_mplier = '0;
        mult_func   = ALU_ADD;
        if (grant_any) begin
            mult_mcand  = req_opa[grant_idx];
            mult_mplier = req_opb[grant_idx];
            mult_func   = req_func[grant_idx];
        end
    end

    // Pointer moves past the winner only; flush keeps fairness history
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Shadow valids track each operation through the multiplier's stages
    always_ff @(posedge clk) begin
        if (rst || pipe_flush) begin
            sh_valid <= '0;
        end else begin
            sh_valid[0] <= grant_any;
            for (int k = 1; k < LAT; k++) begin
                sh_valid[k] <= sh_valid[k-1];
            end
        end
    end

    // Shadow tags need no reset; they are qualified by the shadow valids
    always_ff @(posedge clk) begin
        sh_tag[0] <= req_tag[grant_idx];
        for (int k = 1; k < LAT; k++) begin
            sh_tag[k] <= sh_tag[k-1];
        end
    end

    // Result buffer pointers and count; flush drops any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (rst || pipe_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Capture the multiplier output alongside the tag of the op that produced it
    always_ff @(posedge clk) begin
        if (push && !rst && !pipe_flush) begin
            fifo_tag[wr_ptr] <= sh_tag[LAT-1];
            fifo_res[wr_ptr] <= mult_result;
        end
    end

    assign cdb_valid  = fifo_nonempty & ~rst;
    assign cdb_tag    = fifo_tag[rd_ptr];
    assign cdb_result = fifo_res[rd_ptr];
    assign busy       = ((|sh_valid) | fifo_nonempty) & ~rst;

endmodule
